// File: rtl/delivery_collision_checker_pkg.sv
// Shared constants, state encoding and helpers for the delivery-game collision checker.
// Also used by the map shifter so both blocks agree on map layout.
package delivery_collision_checker_pkg;

    localparam int unsigned DELIVERY_LANES = 4;
    localparam int unsigned DELIVERY_ROWS  = 16;
    localparam int unsigned DELIVERY_ROW_W = 4;
    localparam int unsigned DELIVERY_MAP_W = DELIVERY_ROWS * DELIVERY_ROW_W;
    localparam int unsigned LANE_W         = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_INVULN = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    // Row-0 contents seen in the player's lane.
    typedef struct packed {
        logic obs;
        logic obj;
    } lane_hit_t;

    function automatic logic [DELIVERY_ROW_W-1:0] lane_mask(input logic [LANE_W-1:0] lane);
        return DELIVERY_ROW_W'(1) << lane;
    endfunction

endpackage

// File: rtl/delivery_collision_checker_if.sv
// Map/player inputs and game-status outputs of the collision checker.
// master = game/map side that drives inputs, slave = the checker.
interface delivery_collision_checker_if #(
    parameter int unsigned LIVES_W = 2,
    parameter int unsigned SCORE_W = 8
);
    logic                                                   start;
    logic                                                   map_shifted;
    logic [delivery_collision_checker_pkg::LANE_W-1:0]         player_lane;
    logic [delivery_collision_checker_pkg::DELIVERY_MAP_W-1:0] map_obstacles_flat;
    logic [delivery_collision_checker_pkg::DELIVERY_MAP_W-1:0] map_objectives_flat;
    logic [LIVES_W-1:0]                                     lives;
    logic [SCORE_W-1:0]                                     score;
    logic                                                   hit;
    logic                                                   collect;
    logic                                                   running;
    logic                                                   invulnerable;
    logic                                                   game_over;

    modport master (
        output start, map_shifted, player_lane, map_obstacles_flat, map_objectives_flat,
        input  lives, score, hit, collect, running, invulnerable, game_over
    );

    modport slave (
        input  start, map_shifted, player_lane, map_obstacles_flat, map_objectives_flat,
        output lives, score, hit, collect, running, invulnerable, game_over
    );

endinterface

// File: rtl/delivery_sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over inc.
module delivery_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/delivery_collision_checker.sv
// Detects obstacle hits and objective pickups on the player row, tracks lives/score and game state.
// Optional macro DELIVERY_CONTINUOUS_CHECK_EN: evaluate every cycle with per-row once-only flags.
module delivery_collision_checker
    import delivery_collision_checker_pkg::*;
#(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned LIVES_W      = 2,
    parameter int unsigned SCORE_W      = 8,
    parameter int unsigned INVULN_TICKS = 3
) (
    input logic                         clock,
    input logic                         reset,
    delivery_collision_checker_if.slave bus
);

    localparam int unsigned CNT_W = (INVULN_TICKS > 0) ? $clog2(INVULN_TICKS + 1) : 1;

    state_t                    state;
    logic [LIVES_W-1:0]        lives;
    logic [LIVES_W-1:0]        lives_dec;
    logic [CNT_W-1:0]          invuln_cnt;
    logic                      hit;
    logic                      collect;
    logic                      running;
    logic                      invulnerable;
    logic                      game_over;
    logic [SCORE_W-1:0]        score;
    logic                      score_clear;
    logic                      score_inc;
    logic [DELIVERY_ROW_W-1:0] mask;
    logic [DELIVERY_ROW_W-1:0] row0_obs;
    logic [DELIVERY_ROW_W-1:0] row0_obj;
    lane_hit_t                 lane_hit;
    logic                      active;
    logic                      eval;
    logic                      unused_rows;

`ifdef DELIVERY_CONTINUOUS_CHECK_EN
    logic obs_done;
    logic obj_done;
`endif

    // Player-row decode and evaluation qualification.
    always_comb begin
        mask     = lane_mask(bus.player_lane);
        row0_obs = bus.map_obstacles_flat[DELIVERY_ROW_W-1:0];
        row0_obj = bus.map_objectives_flat[DELIVERY_ROW_W-1:0];
        active   = (state == ST_RUN) || (state == ST_INVULN);
`ifdef DELIVERY_CONTINUOUS_CHECK_EN
        // A fresh row arrives with map_shifted, so stale done flags are ignored that cycle.
        eval         = active;
        lane_hit.obs = (|(row0_obs & mask)) && (bus.map_shifted || !obs_done);
        lane_hit.obj = (|(row0_obj & mask)) && (bus.map_shifted || !obj_done);
`else
        eval         = active && bus.map_shifted;
        lane_hit.obs = |(row0_obs & mask);
        lane_hit.obj = |(row0_obj & mask);
`endif
        lives_dec   = (lives != '0) ? (lives - LIVES_W'(1)) : '0;
        score_clear = !active && bus.start;
        score_inc   = eval && lane_hit.obj;
    end

    assign unused_rows = ^{bus.map_obstacles_flat[DELIVERY_MAP_W-1:DELIVERY_ROW_W],
                           bus.map_objectives_flat[DELIVERY_MAP_W-1:DELIVERY_ROW_W]};

    // Game-state FSM with registered status flags and event pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            lives        <= LIVES_W'(LIVES_INIT);
            invuln_cnt   <= '0;
            hit          <= 1'b0;
            collect      <= 1'b0;
            running      <= 1'b0;
            invulnerable <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            hit     <= 1'b0;
            collect <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        state        <= ST_RUN;
                        lives        <= LIVES_W'(LIVES_INIT);
                        invuln_cnt   <= '0;
                        running      <= 1'b1;
                        invulnerable <= 1'b0;
                        game_over    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (eval) begin
                        collect <= lane_hit.obj;
                        if (lane_hit.obs) begin
                            hit   <= 1'b1;
                            lives <= lives_dec;
                            if (lives_dec == '0) begin
                                state     <= ST_OVER;
                                running   <= 1'b0;
                                game_over <= 1'b1;
                            end else if (INVULN_TICKS != 0) begin
                                state        <= ST_INVULN;
                                invulnerable <= 1'b1;
                                invuln_cnt   <= CNT_W'(INVULN_TICKS);
                            end
                        end
                    end
                end
                ST_INVULN: begin
                    if (eval) begin
                        collect <= lane_hit.obj;
                    end
                    // Protection is counted in map shifts, not cycles.
                    if (bus.map_shifted) begin
                        if (invuln_cnt <= CNT_W'(1)) begin
                            state        <= ST_RUN;
                            invulnerable <= 1'b0;
                            invuln_cnt   <= '0;
                        end else begin
                            invuln_cnt <= invuln_cnt - CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DELIVERY_CONTINUOUS_CHECK_EN
    // Once-per-row flags; a hit swallowed by invulnerability leaves obs_done clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            obs_done <= 1'b0;
            obj_done <= 1'b0;
        end else if (!active) begin
            obs_done <= 1'b0;
            obj_done <= 1'b0;
        end else begin
            if ((state == ST_RUN) && eval && lane_hit.obs) begin
                obs_done <= 1'b1;
            end else if (bus.map_shifted) begin
                obs_done <= 1'b0;
            end
            if (eval && lane_hit.obj) begin
                obj_done <= 1'b1;
            end else if (bus.map_shifted) begin
                obj_done <= 1'b0;
            end
        end
    end
`endif

    delivery_sat_counter #(
        .W(SCORE_W)
    ) u_score (
        .clock (clock),
        .reset (reset),
        .clear (score_clear),
        .inc   (score_inc),
        .value (score)
    );

    assign bus.lives        = lives;
    assign bus.score        = score;
    assign bus.hit          = hit;
    assign bus.collect      = collect;
    assign bus.running      = running;
    assign bus.invulnerable = invulnerable;
    assign bus.game_over    = game_over;

endmodule

// File: tb/tb_delivery_collision_checker.sv
// Directed self-checking bench for delivery_collision_checker (default parameters).
module tb_delivery_collision_checker;
    import delivery_collision_checker_pkg::*;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    delivery_collision_checker_if #(.LIVES_W(2), .SCORE_W(8)) bus_if ();

    delivery_collision_checker #(
        .LIVES_INIT   (3),
        .LIVES_W      (2),
        .SCORE_W      (8),
        .INVULN_TICKS (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    // Upper rows are filled with ones so any use of a row other than row 0 shows up.
    task automatic set_row0(input logic [3:0] obs_row, input logic [3:0] obj_row);
        bus_if.map_obstacles_flat  = {{(DELIVERY_MAP_W - 4){1'b1}}, obs_row};
        bus_if.map_objectives_flat = {{(DELIVERY_MAP_W - 4){1'b1}}, obj_row};
    endtask

    // One map_shifted pulse with the given row 0; returns at the negedge after its evaluation edge.
    task automatic shift(input logic [3:0] obs_row, input logic [3:0] obj_row);
        @(negedge clock);
        set_row0(obs_row, obj_row);
        bus_if.map_shifted = 1'b1;
        @(negedge clock);
        bus_if.map_shifted = 1'b0;
        set_row0(4'b0000, 4'b0000);
    endtask

    task automatic start_game();
        @(negedge clock);
        bus_if.start = 1'b1;
        @(negedge clock);
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        tests++;
        if (bus_if.lives !== 2'd3) begin
            fails++; $display("FAIL reset_lives: got %0d expected 3", bus_if.lives);
        end
        tests++;
        if (bus_if.score !== 8'd0) begin
            fails++; $display("FAIL reset_score: got %0d expected 0", bus_if.score);
        end
        tests++;
        if ({bus_if.hit, bus_if.collect, bus_if.running, bus_if.invulnerable, bus_if.game_over} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus_if.hit, bus_if.collect, bus_if.running, bus_if.invulnerable, bus_if.game_over});
        end
        reset = 1'b0;
        // Shifts in IDLE are ignored.
        bus_if.player_lane = 2'd2;
        shift(4'b0100, 4'b0100);
        tests++;
        if ({bus_if.hit, bus_if.collect, bus_if.running} !== 3'b000 || bus_if.lives !== 2'd3 || bus_if.score !== 8'd0) begin
            fails++;
            $display("FAIL idle_ignore: got hit/collect/running=%b lives=%0d score=%0d expected 000 3 0",
                     {bus_if.hit, bus_if.collect, bus_if.running}, bus_if.lives, bus_if.score);
        end
    endtask

    task automatic test_hit();
        start_game();
        tests++;
        if (bus_if.running !== 1'b1 || bus_if.lives !== 2'd3 || bus_if.score !== 8'd0 || bus_if.game_over !== 1'b0) begin
            fails++;
            $display("FAIL start: got running=%b lives=%0d score=%0d over=%b expected 1 3 0 0",
                     bus_if.running, bus_if.lives, bus_if.score, bus_if.game_over);
        end
        bus_if.player_lane = 2'd2;
        shift(4'b0010, 4'b0000);
        tests++;
        if (bus_if.hit !== 1'b0 || bus_if.lives !== 2'd3) begin
            fails++; $display("FAIL other_lane: got hit=%b lives=%0d expected 0 3", bus_if.hit, bus_if.lives);
        end
        shift(4'b0100, 4'b0000);
        tests++;
        if (bus_if.hit !== 1'b1 || bus_if.lives !== 2'd2 || bus_if.invulnerable !== 1'b1) begin
            fails++;
            $display("FAIL first_hit: got hit=%b lives=%0d invuln=%b expected 1 2 1",
                     bus_if.hit, bus_if.lives, bus_if.invulnerable);
        end
        @(negedge clock);
        tests++;
        if (bus_if.hit !== 1'b0) begin
            fails++; $display("FAIL hit_pulse_width: got %b expected 0", bus_if.hit);
        end
    endtask

    task automatic test_invuln();
        for (int i = 0; i < 3; i++) begin
            shift(4'b0100, 4'b0000);
            tests++;
            if (bus_if.hit !== 1'b0 || bus_if.lives !== 2'd2 || bus_if.invulnerable !== (i < 2) || bus_if.running !== 1'b1) begin
                fails++;
                $display("FAIL invuln_shift%0d: got hit=%b lives=%0d invuln=%b running=%b expected 0 2 %b 1",
                         i, bus_if.hit, bus_if.lives, bus_if.invulnerable, bus_if.running, (i < 2));
            end
        end
    endtask

    task automatic test_fatal();
        bus_if.player_lane = 2'd1;
        shift(4'b0000, 4'b0010);
        tests++;
        if (bus_if.collect !== 1'b1 || bus_if.score !== 8'd1) begin
            fails++; $display("FAIL pickup: got collect=%b score=%0d expected 1 1", bus_if.collect, bus_if.score);
        end
        shift(4'b0010, 4'b0000);
        tests++;
        if (bus_if.hit !== 1'b1 || bus_if.lives !== 2'd1) begin
            fails++; $display("FAIL second_hit: got hit=%b lives=%0d expected 1 1", bus_if.hit, bus_if.lives);
        end
        repeat (3) shift(4'b0000, 4'b0000);
        tests++;
        if (bus_if.invulnerable !== 1'b0 || bus_if.running !== 1'b1) begin
            fails++;
            $display("FAIL back_to_run: got invuln=%b running=%b expected 0 1", bus_if.invulnerable, bus_if.running);
        end
        shift(4'b0010, 4'b0010);
        tests++;
        if (bus_if.hit !== 1'b1 || bus_if.collect !== 1'b1 || bus_if.score !== 8'd2 || bus_if.lives !== 2'd0) begin
            fails++;
            $display("FAIL fatal_both: got hit=%b collect=%b score=%0d lives=%0d expected 1 1 2 0",
                     bus_if.hit, bus_if.collect, bus_if.score, bus_if.lives);
        end
        tests++;
        if (bus_if.game_over !== 1'b1 || bus_if.running !== 1'b0 || bus_if.invulnerable !== 1'b0) begin
            fails++;
            $display("FAIL over_flags: got over=%b running=%b invuln=%b expected 1 0 0",
                     bus_if.game_over, bus_if.running, bus_if.invulnerable);
        end
        shift(4'b0010, 4'b0010);
        tests++;
        if (bus_if.hit !== 1'b0 || bus_if.collect !== 1'b0 || bus_if.lives !== 2'd0 || bus_if.score !== 8'd2 || bus_if.game_over !== 1'b1) begin
            fails++;
            $display("FAIL over_ignore: got hit=%b collect=%b lives=%0d score=%0d over=%b expected 0 0 0 2 1",
                     bus_if.hit, bus_if.collect, bus_if.lives, bus_if.score, bus_if.game_over);
        end
        start_game();
        tests++;
        if (bus_if.running !== 1'b1 || bus_if.lives !== 2'd3 || bus_if.score !== 8'd0 || bus_if.game_over !== 1'b0) begin
            fails++;
            $display("FAIL restart: got running=%b lives=%0d score=%0d over=%b expected 1 3 0 0",
                     bus_if.running, bus_if.lives, bus_if.score, bus_if.game_over);
        end
    endtask

    task automatic test_saturate();
        int exp_score;
        bus_if.player_lane = 2'd0;
        for (int i = 0; i < 300; i++) begin
            shift(4'b0000, 4'b0001);
            exp_score = (i + 1 > 255) ? 255 : i + 1;
            tests++;
            if (bus_if.collect !== 1'b1 || bus_if.score !== 8'(exp_score)) begin
                fails++;
                $display("FAIL saturate_%0d: got collect=%b score=%0d expected 1 %0d",
                         i, bus_if.collect, bus_if.score, exp_score);
            end
        end
        @(negedge clock);
        tests++;
        if (bus_if.collect !== 1'b0 || bus_if.score !== 8'd255) begin
            fails++;
            $display("FAIL saturate_idle: got collect=%b score=%0d expected 0 255", bus_if.collect, bus_if.score);
        end
    endtask

    task automatic test_reset_mid();
        bus_if.player_lane = 2'd0;
        shift(4'b0001, 4'b0000);
        tests++;
        if (bus_if.invulnerable !== 1'b1 || bus_if.lives !== 2'd2) begin
            fails++;
            $display("FAIL pre_reset: got invuln=%b lives=%0d expected 1 2", bus_if.invulnerable, bus_if.lives);
        end
        @(negedge clock);
        set_row0(4'b0001, 4'b0001);
        bus_if.map_shifted = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        bus_if.map_shifted = 1'b0;
        tests++;
        if ({bus_if.hit, bus_if.collect, bus_if.running, bus_if.invulnerable, bus_if.game_over} !== 5'b00000 ||
            bus_if.lives !== 2'd3 || bus_if.score !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid: got flags=%b lives=%0d score=%0d expected 00000 3 0",
                     {bus_if.hit, bus_if.collect, bus_if.running, bus_if.invulnerable, bus_if.game_over},
                     bus_if.lives, bus_if.score);
        end
        reset = 1'b0;
        @(negedge clock);
        set_row0(4'b0000, 4'b0000);
        tests++;
        if ({bus_if.hit, bus_if.collect, bus_if.running} !== 3'b000) begin
            fails++;
            $display("FAIL post_reset: got hit/collect/running=%b expected 000",
                     {bus_if.hit, bus_if.collect, bus_if.running});
        end
    endtask

`ifdef DELIVERY_CONTINUOUS_CHECK_EN
    task automatic test_continuous();
        int collects;
        start_game();
        bus_if.player_lane = 2'd0;
        @(negedge clock);
        set_row0(4'b0000, 4'b1000);
        bus_if.map_shifted = 1'b1;
        @(negedge clock);
        bus_if.map_shifted = 1'b0;
        tests++;
        if (bus_if.collect !== 1'b0) begin
            fails++; $display("FAIL cont_wrong_lane: got collect=%b expected 0", bus_if.collect);
        end
        @(negedge clock);
        bus_if.player_lane = 2'd3;
        collects = 0;
        repeat (8) begin
            @(negedge clock);
            if (bus_if.collect === 1'b1) collects++;
        end
        tests++;
        if (collects != 1 || bus_if.score !== 8'd1) begin
            fails++;
            $display("FAIL cont_once: got collects=%0d score=%0d expected 1 1", collects, bus_if.score);
        end
        set_row0(4'b0000, 4'b0000);
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        clock = 1'b0;
        reset = 1'b1;
        bus_if.start       = 1'b0;
        bus_if.map_shifted = 1'b0;
        bus_if.player_lane = 2'd0;
        set_row0(4'b0000, 4'b0000);

        test_reset();
        test_hit();
        test_invuln();
        test_fatal();
        test_saturate();
        test_reset_mid();
`ifdef DELIVERY_CONTINUOUS_CHECK_EN
        test_continuous();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
